// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit half of the serial character link. Takes one parallel character
// over a valid/ready handshake and shifts it out as start bit, data bits
// (LSB first), optional parity bit and stop bit(s). Every bit is held for
// OVERSAMPLE ticks of the shared 16x baud sample tick.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sampleTick,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txValid,
  output logic                 txReady,
  output logic                 dataOut,
  output logic                 txBusy,
  output logic                 txDone
);

  // The stop field is timed with the same tick counter, extended to cover
  // STOP_BITS bit periods, so the counter is sized for the longest field.
  localparam int STOP_TICKS = STOP_BITS * OVERSAMPLE;
  localparam int TICK_W     = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam int IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic              ODD_SENSE = (PARITY_ODD != 0);
  localparam logic              USE_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               r_state;
  logic [TICK_W-1:0]    r_tickCnt;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_dataOut;
  logic                 r_txReady;
  logic                 r_txBusy;
  logic                 r_txDone;

  state_t               w_nextState;
  logic [TICK_W-1:0]    w_nextTick;
  logic [IDX_W-1:0]     w_nextIdx;
  logic [DATA_BITS-1:0] w_nextShift;
  logic                 w_nextParity;
  logic                 w_nextDataOut;
  logic                 w_nextReady;
  logic                 w_nextBusy;
  logic                 w_nextDone;

  logic                 w_accept;
  logic                 w_bitEnd;
  logic                 w_stopEnd;
  logic [DATA_BITS-1:0] w_shifted;

  // A bit ends on the tick that completes OVERSAMPLE counts; the stop field
  // ends on the tick that completes STOP_BITS bit periods.
  assign w_accept  = txValid & r_txReady;
  assign w_bitEnd  = sampleTick && (r_tickCnt == BIT_LAST);
  assign w_stopEnd = sampleTick && (r_tickCnt == STOP_LAST);
  assign w_shifted = r_shift >> 1;

  // Next-state and next-output decode; every output is registered below so
  // each bit level appears on the same edge that ends the previous bit.
  always_comb begin
    w_nextState   = r_state;
    w_nextTick    = r_tickCnt;
    w_nextIdx     = r_bitIdx;
    w_nextShift   = r_shift;
    w_nextParity  = r_parity;
    w_nextDataOut = r_dataOut;
    w_nextReady   = r_txReady;
    w_nextBusy    = r_txBusy;
    w_nextDone    = 1'b0;

    if ((r_state != IDLE) && sampleTick) begin
      w_nextTick = r_tickCnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_nextDataOut = 1'b1;
        w_nextReady   = 1'b1;
        w_nextBusy    = 1'b0;
        if (w_accept) begin
          w_nextShift   = txData;
          w_nextParity  = (^txData) ^ ODD_SENSE;
          w_nextTick    = '0;
          w_nextIdx     = '0;
          w_nextState   = START;
          w_nextDataOut = 1'b0;
          w_nextReady   = 1'b0;
          w_nextBusy    = 1'b1;
        end
      end

      START: begin
        if (w_bitEnd) begin
          w_nextTick    = '0;
          w_nextState   = DATA;
          w_nextDataOut = r_shift[0];
        end
      end

      DATA: begin
        if (w_bitEnd) begin
          w_nextTick = '0;
          if (r_bitIdx == IDX_LAST) begin
            if (USE_PAR) begin
              w_nextState   = PARITY;
              w_nextDataOut = r_parity;
            end else begin
              w_nextState   = STOP;
              w_nextDataOut = 1'b1;
            end
          end else begin
            w_nextIdx     = r_bitIdx + 1'b1;
            w_nextShift   = w_shifted;
            w_nextDataOut = w_shifted[0];
          end
        end
      end

      PARITY: begin
        if (w_bitEnd) begin
          w_nextTick    = '0;
          w_nextState   = STOP;
          w_nextDataOut = 1'b1;
        end
      end

      STOP: begin
        w_nextDataOut = 1'b1;
        if (w_stopEnd) begin
          w_nextTick  = '0;
          w_nextIdx   = '0;
          w_nextState = IDLE;
          w_nextReady = 1'b1;
          w_nextBusy  = 1'b0;
          w_nextDone  = 1'b1;
        end
      end

      default: begin
        w_nextState   = IDLE;
        w_nextTick    = '0;
        w_nextIdx     = '0;
        w_nextDataOut = 1'b1;
        w_nextReady   = 1'b1;
        w_nextBusy    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tickCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_dataOut <= 1'b1;
      r_txReady <= 1'b1;
      r_txBusy  <= 1'b0;
      r_txDone  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_tickCnt <= w_nextTick;
      r_bitIdx  <= w_nextIdx;
      r_shift   <= w_nextShift;
      r_parity  <= w_nextParity;
      r_dataOut <= w_nextDataOut;
      r_txReady <= w_nextReady;
      r_txBusy  <= w_nextBusy;
      r_txDone  <= w_nextDone;
    end
  end

  assign dataOut = r_dataOut;
  assign txReady = r_txReady;
  assign txBusy  = r_txBusy;
  assign txDone  = r_txDone;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Directed bench for the serial transmitter: one default instance and one
// with even parity enabled. Expected line levels for each frame are queued
// when the character is sent and compared mid-bit as the frame goes out.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       resetSig;
  logic       sampleTick = 1'b0;
  int         tickPhase = 0;
  int         tickDiv = 1;

  logic [7:0] txDataA;
  logic       txValidA;
  logic       readyA, lineA, busyA, doneA;
  logic [7:0] txDataB;
  logic       txValidB;
  logic       readyB, lineB, busyB, doneB;

  int         testsRun = 0;
  int         testsFailed = 0;
  logic       expQ[$];

  int         doneClks, firstTickClk, highRun, riseClk;

  uart_tx_serializer dutA (
    .clk       (clk),
    .reset     (resetSig),
    .sampleTick(sampleTick),
    .txData    (txDataA),
    .txValid   (txValidA),
    .txReady   (readyA),
    .dataOut   (lineA),
    .txBusy    (busyA),
    .txDone    (doneA)
  );

  uart_tx_serializer #(
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dutB (
    .clk       (clk),
    .reset     (resetSig),
    .sampleTick(sampleTick),
    .txData    (txDataB),
    .txValid   (txValidB),
    .txReady   (readyB),
    .dataOut   (lineB),
    .txBusy    (busyB),
    .txDone    (doneB)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Baud sample tick: one pulse every tickDiv clocks, changed on the falling edge.
  always @(negedge clk) begin
    tickPhase  = tickPhase + 1;
    sampleTick = ((tickPhase % tickDiv) == 0);
  end

  // Safety net in case a wait is never satisfied.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic lineOf(input int sel);
    return (sel == 0) ? lineA : lineB;
  endfunction

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? readyA : readyB;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? busyA : busyB;
  endfunction

  function automatic logic doneOf(input int sel);
    return (sel == 0) ? doneA : doneB;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level of every bit of a frame, start bit first.
  task automatic pushFrame(input int sel, input logic [7:0] data);
    expQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) expQ.push_back(data[i]);
    if (sel == 1) expQ.push_back(^data);
    expQ.push_back(1'b1);
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] data, input bit hold);
    int w;
    w = 0;
    while (readyOf(sel) !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("readyBeforeSend", readyOf(sel), 1);
    if (sel == 0) begin
      txDataA = data; txValidA = 1'b1;
    end else begin
      txDataB = data; txValidB = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput("acceptLine", lineOf(sel), 0);
    checkOutput("acceptReady", readyOf(sel), 0);
    checkOutput("acceptBusy", busyOf(sel), 1);
    if (!hold) begin
      if (sel == 0) txValidA = 1'b0;
      else          txValidB = 1'b0;
    end
    pushFrame(sel, data);
  endtask

  // Follows one frame from the edge after acceptance until txDone.
  // mode 1: disturb txData/txValid mid-frame; mode 2: reset during data bit 3.
  task automatic monitorFrame(input int sel, input int frameTicks, input int mode,
                              output int dClks, output int fTick, output int hRun,
                              output int rClk);
    int   k, clks, pulses;
    bit   seenRise, finished;
    logic expBit;
    k = 0; clks = 0; seenRise = 0; finished = 0;
    dClks = 0; fTick = 0; hRun = 0; rClk = 0;
    while (!finished && clks < 6000) begin
      @(posedge clk); #1;
      clks++;
      if (sampleTick) begin
        k++;
        if (k == 1) fTick = clks;
      end
      if (lineOf(sel)) begin
        hRun++;
        if (!seenRise) begin seenRise = 1; rClk = clks; end
      end else begin
        hRun = 0;
      end
      if (mode == 1 && clks == 40) txDataA = 8'hFF;
      if (mode == 1 && clks == 60) txValidA = 1'b0;
      if (mode == 1 && clks == 61) txValidA = 1'b1;
      if (doneOf(sel)) begin
        finished = 1;
        dClks = clks;
        checkOutput("doneTickCount", k, frameTicks);
        checkOutput("doneReady", readyOf(sel), 1);
        checkOutput("doneBusy", busyOf(sel), 0);
        checkOutput("doneLine", lineOf(sel), 1);
        checkOutput("queueEmptyAtDone", expQ.size(), 0);
      end else if (sampleTick && (k % 16) == 8) begin
        expBit = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
        checkOutput("midBitLine", lineOf(sel), expBit);
        checkOutput("midBitBusy", busyOf(sel), 1);
        if (mode == 2 && k == 72) begin
          resetSig = 1'b1;
          @(posedge clk); #1;
          resetSig = 1'b0;
          checkOutput("resetLine", lineOf(sel), 1);
          checkOutput("resetReady", readyOf(sel), 1);
          checkOutput("resetBusy", busyOf(sel), 0);
          checkOutput("resetDone", doneOf(sel), 0);
          pulses = 0;
          repeat (20) begin
            @(posedge clk); #1;
            if (doneOf(sel)) pulses++;
          end
          checkOutput("noDoneAfterReset", pulses, 0);
          expQ.delete();
          finished = 1;
        end
      end
    end
    checkOutput("frameEnded", finished, 1);
  endtask

  initial begin
    int dummy0, dummy1, dummy2, dummy3;
    resetSig = 1'b1;
    txDataA = 8'h00; txValidA = 1'b0;
    txDataB = 8'h00; txValidB = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstLine", lineA, 1);
    checkOutput("rstReady", readyA, 1);
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstDone", doneA, 0);
    resetSig = 1'b0;
    @(posedge clk); #1;

    // 0x55 with a tick every clock
    applyStimulus(0, 8'h55, 1'b0);
    monitorFrame(0, 160, 0, doneClks, firstTickClk, highRun, riseClk);
    checkOutput("frame55Clks", doneClks, 160);
    @(posedge clk); #1;
    checkOutput("donePulseWidth", doneA, 0);
    checkOutput("readyAfterDone", readyA, 1);

    // 0xA3 with even parity
    applyStimulus(1, 8'hA3, 1'b0);
    monitorFrame(1, 176, 0, doneClks, firstTickClk, highRun, riseClk);
    checkOutput("frameA3Clks", doneClks, 176);
    @(posedge clk); #1;
    checkOutput("parDonePulseWidth", doneB, 0);

    // 0x80 with a tick every fourth clock
    tickDiv = 4;
    applyStimulus(0, 8'h80, 1'b0);
    monitorFrame(0, 160, 0, doneClks, firstTickClk, highRun, riseClk);
    checkOutput("slowFrameSpan", doneClks - firstTickClk, 159 * 4);
    checkOutput("slowBit7Start", riseClk - firstTickClk, 127 * 4);
    tickDiv = 1;
    repeat (8) @(posedge clk);
    #1;

    // back-to-back 0x00 then 0xFF with txValid held
    applyStimulus(0, 8'h00, 1'b1);
    monitorFrame(0, 160, 1, doneClks, firstTickClk, highRun, riseClk);
    checkOutput("b2bFirstClks", doneClks, 160);
    checkOutput("b2bGapHigh", highRun, 17);
    @(posedge clk); #1;
    checkOutput("b2bAcceptLine", lineA, 0);
    checkOutput("b2bAcceptBusy", busyA, 1);
    txValidA = 1'b0;
    pushFrame(0, 8'hFF);
    monitorFrame(0, 160, 0, doneClks, dummy0, dummy1, dummy2);
    checkOutput("b2bSecondClks", doneClks, 160);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("noThirdFrameBusy", busyA, 0);
    checkOutput("noThirdFrameLine", lineA, 1);

    // reset during data bit 3, then a clean resend
    applyStimulus(0, 8'h3C, 1'b0);
    monitorFrame(0, 160, 2, doneClks, dummy0, dummy1, dummy2);
    applyStimulus(0, 8'h3C, 1'b0);
    monitorFrame(0, 160, 0, doneClks, dummy0, dummy1, dummy3);
    checkOutput("resendClks", doneClks, 160);

    // reset held with txValid asserted
    resetSig = 1'b1;
    txDataA  = 8'h5A;
    txValidA = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      checkOutput("heldRstLine", lineA, 1);
    end
    checkOutput("heldRstBusy", busyA, 0);
    txValidA = 1'b0;
    resetSig = 1'b0;
    @(posedge clk); #1;
    checkOutput("afterHeldRstReady", readyA, 1);
    checkOutput("afterHeldRstBusy", busyA, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
